// File: rtl/alu_op_issuer_if.sv
// Request, ALU-drive and response signals of the ALU op issuer.
// The issuer uses the slave modport; the control logic and ALU side use master.
interface alu_op_issuer_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_opcode;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic [1:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_opcode;

  logic              err_sticky;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_out, rsp_ready,
    output req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, rsp_opcode, err_sticky
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_out, rsp_ready,
    input  req_ready, alu_opcode, alu_a, alu_b, rsp_valid, rsp_data, rsp_opcode, err_sticky
  );
endinterface

// File: rtl/alu_op_issuer.sv
// Issues one op at a time to a combinational ALU, waits a settle window, returns the result.
// Define ALU_ISSUER_CHECK_EN to enable the result self-check driving err_sticky.
module alu_op_issuer #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_op_issuer_if.slave  bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 16) begin : g_bad_settle
    $error("alu_op_issuer: SETTLE_CYCLES must be in 1..16");
  end

  localparam int unsigned CntW = 4;
  typedef logic [CntW-1:0] cnt_t;
  localparam cnt_t CntInit = cnt_t'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StResp
  } state_e;

  state_e            state_q, state_d;
  cnt_t              cnt_q, cnt_d;
  logic              accept, capture, rsp_done;

  logic [1:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic [1:0]        rsp_opcode_q;
  logic              err_q, err_d;

  // Next-state and handshake strobes
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = CntInit;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ALU operands change only on acceptance so alu_out is stable for the whole window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode_q <= 2'b00;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
    end else if (accept) begin
      alu_opcode_q <= bus.req_opcode;
      alu_a_q      <= bus.req_a;
      alu_b_q      <= bus.req_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_opcode_q <= 2'b00;
    end else if (capture) begin
      rsp_valid_q  <= 1'b1;
      rsp_data_q   <= bus.alu_out;
      rsp_opcode_q <= alu_opcode_q;
    end else if (rsp_done) begin
      rsp_valid_q  <= 1'b0;
    end
  end

`ifdef ALU_ISSUER_CHECK_EN
  logic [DATA_W-1:0] model_out;
  logic              model_chk;

  // The function opcode has no reference behaviour, so it is never flagged
  always_comb begin
    model_out = '0;
    model_chk = 1'b1;
    unique case (alu_opcode_q)
      2'b00:   model_out = alu_a_q + alu_b_q;
      2'b01:   model_out = alu_a_q ^ alu_b_q;
      2'b10:   model_out = ~(alu_a_q & alu_b_q);
      default: model_chk = 1'b0;
    endcase
  end

  assign err_d = err_q | (capture & model_chk & (bus.alu_out != model_out));
`else
  assign err_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.err_sticky = err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Randomized scoreboard bench for alu_op_issuer with an in-bench ALU and reference model.
module tb_alu_op_issuer;
  localparam int unsigned DW     = 8;
  localparam int          SETTLE = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_op_issuer_if #(.DATA_W(DW)) bus ();

  alu_op_issuer #(
    .DATA_W       (DW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Behaviour of the attached ALU; opcode 11 is an arbitrary bench-defined function
  function automatic logic [7:0] ref_alu(logic [1:0] op, logic [7:0] a, logic [7:0] b);
    int s;
    case (op)
      2'b00: begin
        s = (int'(a) + int'(b)) % 256;
        return 8'(s);
      end
      2'b01:   return a ^ b;
      2'b10:   return ~(a & b);
      default: return 8'({a[6:0], 1'b0} ^ b);
    endcase
  endfunction

  logic       stub_en = 1'b0;
  logic [7:0] stub_val = 8'h00;
  assign bus.alu_out = stub_en ? stub_val : ref_alu(bus.alu_opcode, bus.alu_a, bus.alu_b);

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    int         rise;
  } exp_t;
  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every response and checks hold-while-stalled
  logic       prev_valid = 1'b0;
  logic [7:0] held_data;
  logic [1:0] held_op;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!prev_valid) begin
        check("rsp_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          check("rsp_latency", cyc, sb[0].rise);
          check("rsp_data", bus.rsp_data, sb[0].data);
          check("rsp_opcode", bus.rsp_opcode, sb[0].op);
        end
        held_data = bus.rsp_data;
        held_op   = bus.rsp_opcode;
      end else begin
        check("rsp_data_hold", bus.rsp_data, held_data);
        check("rsp_opcode_hold", bus.rsp_opcode, held_op);
      end
      check("req_ready_busy", bus.req_ready, 1'b0);
      if (bus.rsp_ready) begin
        if (sb.size() > 0) void'(sb.pop_front());
        prev_valid = 1'b0;
      end else begin
        prev_valid = 1'b1;
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // rsp_ready randomizer, active only when rr_rand is set
  bit rr_rand = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 of the acceptance edge
  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output int acc);
    bit   rdy;
    bit   done;
    exp_t e;
    done = 1'b0;
    acc  = -1;
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
        acc  = cyc;
        bus.req_valid = 1'b0;
        e.op   = op;
        e.data = stub_en ? stub_val : ref_alu(op, a, b);
        e.rise = acc + SETTLE;
        sb.push_back(e);
        check("alu_opcode", bus.alu_opcode, op);
        check("alu_a", bus.alu_a, a);
        check("alu_b", bus.alu_b, b);
        check("req_ready_after_accept", bus.req_ready, 1'b0);
      end
    end
    if (!done) begin
      bus.req_valid = 1'b0;
      check("accept_timeout", 32'(done), 32'd1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check({tag, "_alu_opcode"}, bus.alu_opcode, 2'b00);
    check({tag, "_alu_a"}, bus.alu_a, 8'h00);
    check({tag, "_alu_b"}, bus.alu_b, 8'h00);
    check({tag, "_rsp_data"}, bus.rsp_data, 8'h00);
    check({tag, "_rsp_opcode"}, bus.rsp_opcode, 2'b00);
    check({tag, "_err_sticky"}, bus.err_sticky, 1'b0);
  endtask

  // Request driven during reset must be ignored
  task automatic do_reset();
    rst_n = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_opcode = 2'b10;
    bus.req_a      = 8'h77;
    bus.req_b      = 8'h66;
    #1;
    check_reset_vals("rst_low");
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    sb.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("rst_rel");
  endtask

  logic err_exp;
  int   acc, prev_acc;

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 2'b00;
    bus.req_a      = 8'h00;
    bus.req_b      = 8'h00;
    bus.rsp_ready  = 1'b1;
`ifdef ALU_ISSUER_CHECK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    @(posedge clk);
    #1;

    // T1 reset
    do_reset();

    // T2 add wrap
    issue(2'b00, 8'hFF, 8'h02, acc);
    drain();

    // T3 backpressure with an ignored second request
    bus.rsp_ready = 1'b0;
    issue(2'b01, 8'hA5, 8'h0F, acc);
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("bp_rsp_valid", bus.rsp_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid  = (i == 1);
      bus.req_opcode = 2'b00;
      bus.req_a      = 8'h11;
      bus.req_b      = 8'h22;
      @(posedge clk);
      #1;
      check("bp_req_ready", bus.req_ready, 1'b0);
      check("bp_alu_a", bus.alu_a, 8'hA5);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rsp_valid_drop", bus.rsp_valid, 1'b0);
    check("bp_idle", bus.req_ready, 1'b1);
    check("bp_sb_empty", sb.size(), 0);

    // T4 reset pulse while settling aborts the op
    issue(2'b01, 8'h3C, 8'h55, acc);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check_reset_vals("abort");
    #3;
    rst_n = 1'b1;
    repeat (SETTLE + 3) begin
      @(posedge clk);
      #1;
      check("abort_no_rsp", bus.rsp_valid, 1'b0);
    end

    // T5 stream of all four opcodes at full throughput
    prev_acc = -1;
    for (int i = 0; i < 4; i++) begin
      issue(2'(i), (i == 2) ? 8'hF0 : 8'(8'h31 * (i + 1)), (i == 2) ? 8'h3C : 8'(8'h5B + i), acc);
      if (prev_acc >= 0) check("throughput", acc - prev_acc, SETTLE + 2);
      prev_acc = acc;
    end
    drain();

    // Randomized ops with random backpressure and gaps
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), acc);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rr_rand = 1'b0;
    bus.rsp_ready = 1'b1;
    check("rand_err_sticky", bus.err_sticky, 1'b0);

    // T6 self-check with a stub ALU
    stub_en  = 1'b1;
    stub_val = 8'h5A;
    issue(2'b11, 8'h12, 8'h34, acc);
    drain();
    check("func_no_err", bus.err_sticky, 1'b0);
    stub_val = 8'h00;
    issue(2'b01, 8'h01, 8'h02, acc);
    repeat (SETTLE - 1) begin
      @(posedge clk);
      #1;
    end
    check("err_before_capture", bus.err_sticky, 1'b0);
    @(posedge clk);
    #1;
    check("err_at_capture", bus.err_sticky, err_exp);
    drain();
    stub_en = 1'b0;
    issue(2'b00, 8'h10, 8'h20, acc);
    drain();
    check("err_sticky_holds", bus.err_sticky, err_exp);
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
